// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generator, synchronous imem request port and a FQ_DEPTH-entry fetch queue.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/flush performance counters.
module if_fetch_queue #(
    parameter int unsigned         XLEN     = 32,
    parameter int unsigned         INST_W   = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int unsigned         FQ_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pc_src,
    input  logic [XLEN-1:0]        new_pc,
    input  logic                   stall_if,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [INST_W-1:0]      imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_plus4,
    output logic [INST_W-1:0]      out_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic              inflight;
    logic [XLEN-1:0]   inflight_pc;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  credit;

    logic [XLEN-1:0]   mem_pc    [FQ_DEPTH];
    logic [INST_W-1:0] mem_instr [FQ_DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Queue slots already promised (stored + in flight) gate new requests, so a return always has room.
    assign credit    = count + CNT_W'(inflight);
    assign issue     = !rst && !pc_src && !stall_if && (credit < CNT_W'(FQ_DEPTH));
    assign push      = inflight && !pc_src;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !pc_src;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign out_pc       = out_valid ? mem_pc[head_ptr] : '0;
    assign out_pc_plus4 = out_valid ? (mem_pc[head_ptr] + XLEN'(4)) : '0;
    assign out_instr    = out_valid ? mem_instr[head_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count       <= '0;
        end else if (pc_src) begin
            // Redirect drops the queue and whatever response is still on its way back.
            fetch_pc <= new_pc & ~XLEN'(3);
            inflight <= 1'b0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail_ptr]    <= inflight_pc;
            mem_instr[tail_ptr] <= imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (pc_src && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
